// File: rtl/mc_sequencer_if.sv
// Shared memory-port handshake between the sequencer and the memory system.
interface mc_sequencer_if;
    logic memReq;
    logic memWe;
    logic memIsFetch;
    logic memAck;

    modport master (
        output memReq,
        output memWe,
        output memIsFetch,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memIsFetch,
        output memAck
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the MiniRiscV core: walks each instruction
// through fetch/decode/exec/mem/writeback, arbitrates the single memory port,
// and keeps cycle/retire counters plus a memory-timeout fault.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          inst,
    input  logic                 branchTaken,
    mc_sequencer_if.master       mem,
    output logic                 irWrite,
    output logic                 pcWrite,
    output logic [1:0]           pcSel,
    output logic                 regWrite,
    output logic [1:0]           wbSel,
    output logic                 aluSrcImm,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [31:0]          cycles,
    output logic [31:0]          instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        retire;
    logic        timeout;
    logic        counting;

    // Only the opcode field steers sequencing; the rest of the word is for the datapath.
    logic        unused_inst;
    assign unused_inst = ^inst[31:7];

    logic [6:0] opc;
    assign opc = inst[6:0];

    logic is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_sys, is_legal, uses_imm;
    assign is_r      = (opc == 7'b0110011);
    assign is_ialu   = (opc == 7'b0010011);
    assign is_load   = (opc == 7'b0000011);
    assign is_store  = (opc == 7'b0100011);
    assign is_branch = (opc == 7'b1100011);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_sys    = (opc == 7'b1110011);
    assign is_legal  = is_r | is_ialu | is_load | is_store | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc | is_sys;
    assign uses_imm  = is_ialu | is_load | is_store | is_jalr | is_lui | is_auipc;

    // A request cycle that is not acknowledged and has used up its budget faults;
    // an ack in that same cycle wins.
    assign timeout  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.memAck &&
                      (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign counting = (state_q >= S_FETCH) && (state_q <= S_WB);
    assign retire   = ((state_q == S_EXEC) && is_branch) ||
                      ((state_q == S_MEM) && is_store && mem.memAck) ||
                      (state_q == S_WB);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem.memAck)  state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                if (is_sys)         state_d = S_HALT;
                else if (!is_legal) state_d = S_FAULT;
                else                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch)                state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else                          state_d = S_WB;
            end
            S_MEM: begin
                if (mem.memAck)   state_d = is_store ? S_FETCH : S_WB;
                else if (timeout) state_d = S_FAULT;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    // Strobes, combinational from state, opcode, branch result and ack.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSel        = 2'b00;
        regWrite     = 1'b0;
        wbSel        = 2'b00;
        aluSrcImm    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                irWrite      = mem.memAck;
            end
            S_EXEC: begin
                aluSrcImm = uses_imm;
                if (is_branch) begin
                    pcWrite = 1'b1;
                    pcSel   = branchTaken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                aluSrcImm = 1'b1;
                if (is_store && mem.memAck) pcWrite = 1'b1;
            end
            S_WB: begin
                regWrite  = 1'b1;
                pcWrite   = 1'b1;
                aluSrcImm = uses_imm;
                if (is_load)               wbSel = 2'b01;
                else if (is_jal || is_jalr) wbSel = 2'b10;
                if (is_jal)       pcSel = 2'b01;
                else if (is_jalr) pcSel = 2'b10;
            end
            default: ;
        endcase
    end

    assign mem.memReq     = mem_req;
    assign mem.memWe      = mem_we;
    assign mem.memIsFetch = mem_is_fetch;
    assign state          = state_q;
    assign halted         = (state_q == S_HALT);
    assign fault          = (state_q == S_FAULT);

    // Unacknowledged request cycles; restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          wait_cnt <= '0;
        else if (state_d != state_q)                       wait_cnt <= '0;
        else if ((state_q == S_FETCH) || (state_q == S_MEM)) wait_cnt <= wait_cnt + 8'd1;
    end

    // Active-cycle and retired-instruction counters, both wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            if (counting) cycles  <= cycles + 32'd1;
            if (retire)   instret <= instret + 32'd1;
        end
    end

endmodule
